// File: rtl/simplebus_mem_responder.sv
// Memory responder on a valid/ready request/response bus. It supports single reads and writes,
// and 8-beat critical-word-first bursts that wrap within an aligned line.
module simplebus_mem_responder #(
  parameter int unsigned LATENCY = 2,   // 1..15
  parameter int unsigned ADDR_W  = 10   // >= 4; memory holds 2**ADDR_W 64-bit words
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [31:0] req_bits_addr,
  input  logic [2:0]  req_bits_size,
  input  logic [3:0]  req_bits_cmd,
  input  logic [7:0]  req_bits_wmask,
  input  logic [63:0] req_bits_wdata,
  input  logic [15:0] req_bits_user,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [3:0]  resp_bits_cmd,
  output logic [63:0] resp_bits_rdata,
  output logic [15:0] resp_bits_user
);

  localparam logic [3:0] CmdRead       = 4'b0000;
  localparam logic [3:0] CmdWrite      = 4'b0001;
  localparam logic [3:0] CmdReadBurst  = 4'b0010;
  localparam logic [3:0] CmdWriteBurst = 4'b0011;
  localparam logic [3:0] CmdWriteResp  = 4'b0101;
  localparam logic [3:0] CmdReadLast   = 4'b0110;
  localparam logic [3:0] CmdWriteLast  = 4'b0111;
  localparam logic [3:0] LatLoad       = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StWburst} state_e;
  typedef enum logic [1:0] {TxRead, TxBurst, TxWrite, TxOther} txn_e;

  state_e            state_q;
  txn_e              txn_q;
  logic [3:0]        cnt_q;
  logic [2:0]        beat_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       user_q;

  logic [63:0]       mem [2**ADDR_W];

  logic              req_fire;
  logic              mem_we;
  logic [2:0]        beat_nxt;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] beat_idx;
  logic [ADDR_W-1:0] next_idx;
  logic [ADDR_W-1:0] mem_widx;
  logic              unused_bits;

  assign unused_bits = ^{req_bits_size, req_bits_addr[31:ADDR_W+3], req_bits_addr[2:0]};

  assign req_ready = !rst && (state_q == StIdle || state_q == StWburst);
  assign req_fire  = req_valid && req_ready;
  assign req_idx   = req_bits_addr[ADDR_W+2:3];
  assign beat_nxt  = beat_q + 3'd1;
  // Burst beats keep the line bits of the start index and wrap the low three bits.
  assign beat_idx  = {base_q[ADDR_W-1:3], base_q[2:0] + beat_q};
  assign next_idx  = {base_q[ADDR_W-1:3], base_q[2:0] + beat_nxt};

  always_comb begin
    mem_we   = 1'b0;
    mem_widx = req_idx;
    if (req_fire) begin
      if (state_q == StIdle) begin
        mem_we = (req_bits_cmd == CmdWrite) || (req_bits_cmd == CmdWriteBurst);
      end else begin
        mem_widx = beat_idx;
        mem_we   = (req_bits_cmd == CmdWriteBurst) || (req_bits_cmd == CmdWriteLast);
      end
    end
  end

  // Memory contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (req_bits_wmask[b]) mem[mem_widx][8*b +: 8] <= req_bits_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      txn_q           <= TxOther;
      cnt_q           <= 4'd0;
      beat_q          <= 3'd0;
      base_q          <= '0;
      user_q          <= 16'd0;
      resp_valid      <= 1'b0;
      resp_bits_cmd   <= 4'd0;
      resp_bits_rdata <= 64'd0;
      resp_bits_user  <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            base_q  <= req_idx;
            user_q  <= req_bits_user;
            cnt_q   <= LatLoad;
            beat_q  <= 3'd0;
            state_q <= StWait;
            case (req_bits_cmd)
              CmdRead:      txn_q <= TxRead;
              CmdWrite:     txn_q <= TxWrite;
              CmdReadBurst: txn_q <= TxBurst;
              CmdWriteBurst: begin
                txn_q   <= TxWrite;
                beat_q  <= 3'd1;
                state_q <= StWburst;
              end
              default:      txn_q <= TxOther;
            endcase
          end
        end
        StWburst: begin
          if (req_fire) begin
            if (req_bits_cmd == CmdWriteBurst) begin
              beat_q <= beat_nxt;
            end else begin
              cnt_q   <= LatLoad;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q        <= StResp;
            resp_valid     <= 1'b1;
            resp_bits_user <= user_q;
            beat_q         <= 3'd0;
            unique case (txn_q)
              TxRead: begin
                resp_bits_cmd   <= CmdReadLast;
                resp_bits_rdata <= mem[base_q];
              end
              TxBurst: begin
                resp_bits_cmd   <= CmdRead;
                resp_bits_rdata <= mem[base_q];
              end
              TxWrite: begin
                resp_bits_cmd   <= CmdWriteResp;
                resp_bits_rdata <= 64'd0;
              end
              TxOther: begin
                resp_bits_cmd   <= CmdReadLast;
                resp_bits_rdata <= 64'd0;
              end
            endcase
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            if (txn_q == TxBurst && beat_q != 3'd7) begin
              beat_q          <= beat_nxt;
              resp_bits_rdata <= mem[next_idx];
              resp_bits_cmd   <= (beat_nxt == 3'd7) ? CmdReadLast : CmdRead;
            end else begin
              resp_valid <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/simplebus_mem_responder.md
SIMPLEBUS_MEM_RESPONDER -- requirements
Module: simplebus_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance to first response beat; legal range 1..15.
REQ-002 Parameter ADDR_W, default 10: log2 of memory depth in 64-bit words; word index = req_bits_addr[ADDR_W+2:3].
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_ready  output  1  responder can accept a request beat.
REQ-006 req_valid  input  1  initiator presents a request beat.
REQ-007 req_bits_addr  input  32  byte address.
REQ-008 req_bits_size  input  3  log2 access size; accepted, not used for decode.
REQ-009 req_bits_cmd  input  4  request command.
REQ-010 req_bits_wmask  input  8  byte write enables.
REQ-011 req_bits_wdata  input  64  write data.
REQ-012 req_bits_user  input  16  opaque tag, echoed in response.
REQ-013 resp_ready  input  1  initiator can accept a response beat.
REQ-014 resp_valid  output  1  response beat presented.
REQ-015 resp_bits_cmd  output  4  response command.
REQ-016 resp_bits_rdata  output  64  read data.
REQ-017 resp_bits_user  output  16  user tag of the owning request.

Function
REQ-018 A beat transfers on a posedge where valid and ready are both 1; no other condition transfers a beat.
REQ-019 States: IDLE, WAIT, RESP, WBURST.
REQ-020 req_ready = 1 in IDLE and WBURST only; 0 in WAIT and RESP.
REQ-021 IDLE, accepted cmd 0001 (write): memory word written at acceptance edge, bytes per wmask; -> WAIT; one response, cmd 0101 (writeResp), rdata 0.
REQ-022 IDLE, accepted cmd 0000 (read): -> WAIT; one response, cmd 0110 (readLast), rdata = memory word at addr.
REQ-023 IDLE, accepted cmd 0010 (readBurst): -> WAIT; 8 responses, word index critical-word-first, wrapping within the aligned 8-word line (index[2:0] increments mod 8, upper bits fixed); beats 1-7 cmd 0000, beat 8 cmd 0110.
REQ-024 IDLE, accepted cmd 0011 (writeBurst): word written per wmask; -> WBURST; no response.
REQ-025 WBURST: accepted cmd 0011 writes the next word (wrap within line as REQ-023), stays in WBURST; accepted cmd 0111 (writeLast) writes its word, -> WAIT, one response cmd 0101.
REQ-026 WBURST: accepted beat with any other cmd performs no write, terminates the burst, -> WAIT, one response cmd 0101.
REQ-027 WBURST: more than 8 write beats wrap within the line, overwriting earlier words; no error.
REQ-028 IDLE: any other cmd is accepted, -> WAIT, one response cmd 0110, rdata 0, no memory access.
REQ-029 Burst write-beat address = latched start index plus beat count; req_bits_addr ignored on beats after the first.
REQ-030 WAIT: counter loaded at acceptance; resp_valid first asserts exactly LATENCY cycles after the acceptance edge; -> RESP.
REQ-031 RESP: resp_valid, cmd, rdata, user held stable until handshake; user = user of the first beat of the transaction.
REQ-032 RESP handshake on non-final beat: next beat presented the following cycle (resp_valid stays 1 when ready held high); final beat handshake: -> IDLE, resp_valid 0 next cycle.
REQ-033 Read data sampled from memory for each beat at presentation; a write cannot intervene within a transaction.
REQ-034 At most one transaction outstanding; no request accepted until the final response handshake completes.

Reset
REQ-035 rst=1 at a posedge: state IDLE, counters 0, resp_valid 0, resp_bits_cmd/rdata/user 0, req_ready 0 while rst=1.
REQ-036 First cycle with rst=0: req_ready 1.
REQ-037 Reset mid-transaction aborts it with no response; memory contents not reset; writes already accepted persist.

Verification
REQ-038 Write 0001 addr 0x40 wdata 0x1122334455667788 wmask 0xFF user 0x0A; read 0000 addr 0x40 -> readLast rdata 0x1122334455667788 user 0x0A; resp_valid rises exactly LATENCY cycles after acceptance.
REQ-039 Write wmask 0x0F data 0xAAAAAAAAAAAAAAAA over word 0x1122334455667788 -> read returns 0x11223344AAAAAAAA.
REQ-040 Line 0x100..0x13F preloaded word i = i; readBurst addr 0x128 -> rdata 5,6,7,0,1,2,3,4; cmd 0000 x7 then 0110.
REQ-041 readBurst with resp_ready toggled 1/0 per cycle -> each beat held stable while stalled; no beat lost or duplicated; req_ready 0 throughout.
REQ-042 writeBurst addr 0x200 three 0011 beats + 0111 beat -> one 0101 response; words 0x200..0x218 readback correct; rst asserted during a later WAIT -> no response, req_ready 1 the cycle after rst drops.
